// File: rtl/bram_reader_pkg.sv
// Shared types for the BRAM read-port clients: FSM encoding and credit width.
package bram_reader_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;
  localparam int OUTST_W = 2;
endpackage

// File: rtl/credit_counter.sv
// Saturating up/down credit counter; AVAIL already counts a same-cycle return.
module credit_counter
  import bram_reader_pkg::*;
#(
  parameter int W = OUTST_W
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         INC,
  input  logic         DEC,
  input  logic [W-1:0] LIMIT,
  output logic         AVAIL
);
  logic [W-1:0] count_q, count_d;

  // count - DEC < LIMIT, rearranged so it cannot underflow
  assign AVAIL = {1'b0, count_q} < ({1'b0, LIMIT} + {{W{1'b0}}, DEC});

  always_comb begin
    count_d = count_q;
    if (INC && !DEC && count_q != LIMIT)
      count_d = count_q + W'(1);
    else if (DEC && !INC && count_q != '0)
      count_d = count_q - W'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) count_q <= '0;
    else        count_q <= count_d;
  end
endmodule

// File: rtl/bram_scan_reader.sv
// Strided read client for one BRAM read port; streams responses straight to the consumer.
module bram_scan_reader
  import bram_reader_pkg::*;
#(
  parameter int addr_width      = 1,
  parameter int data_width      = 1,
  parameter int max_outstanding = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  CMD_EN,
  input  logic [addr_width-1:0] CMD_BASE,
  input  logic [addr_width-1:0] CMD_STRIDE,
  input  logic [addr_width:0]   CMD_LEN,
  output logic                  CMD_RDY,
  output logic [addr_width-1:0] RD_ADDR,
  output logic                  RD_EN,
  input  logic                  RD_RDY,
  input  logic [data_width-1:0] RES,
  input  logic                  RES_RDY,
  output logic                  RES_EN,
  output logic [data_width-1:0] OUT_DATA,
  output logic                  OUT_LAST,
  output logic                  OUT_RDY,
  input  logic                  OUT_EN,
  output logic                  BUSY,
  output logic                  DONE
);
  localparam int LW = addr_width + 1;

  state_e                state_q, state_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [addr_width-1:0] stride_q, stride_d;
  logic [LW-1:0]         to_issue_q, to_issue_d;
  logic [LW-1:0]         to_deliver_q, to_deliver_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cmd_rdy_q, cmd_rdy_d;
  logic                  avail;

  credit_counter #(.W(OUTST_W)) u_credit (
    .CLK   (CLK),
    .RST_N (RST_N),
    .INC   (RD_EN),
    .DEC   (RES_EN),
    .LIMIT (OUTST_W'(max_outstanding)),
    .AVAIL (avail)
  );

  assign OUT_DATA = RES;
  assign OUT_RDY  = RES_RDY & busy_q;
  assign RES_EN   = OUT_EN & OUT_RDY;
  assign OUT_LAST = OUT_RDY & (to_deliver_q == LW'(1));
  // avail sees this cycle's RES_EN, so a returned credit is reused immediately
  assign RD_EN    = (state_q == ISSUE) & (to_issue_q != '0) & RD_RDY & avail;
  assign RD_ADDR  = addr_q;
  assign CMD_RDY  = cmd_rdy_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    stride_d     = stride_q;
    to_issue_d   = to_issue_q;
    to_deliver_d = to_deliver_q;
    done_d       = 1'b0;
    if (RES_EN) to_deliver_d = to_deliver_q - LW'(1);
    case (state_q)
      IDLE: begin
        if (CMD_EN) begin
          addr_d       = CMD_BASE;
          stride_d     = CMD_STRIDE;
          to_issue_d   = CMD_LEN;
          to_deliver_d = CMD_LEN;
          if (CMD_LEN == '0) done_d = 1'b1;
          else               state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (RD_EN) begin
          addr_d     = addr_q + stride_q;
          to_issue_d = to_issue_q - LW'(1);
          if (to_issue_q == LW'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (to_deliver_d == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d    = (state_d != IDLE);
    cmd_rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      stride_q     <= '0;
      to_issue_q   <= '0;
      to_deliver_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cmd_rdy_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      stride_q     <= stride_d;
      to_issue_q   <= to_issue_d;
      to_deliver_q <= to_deliver_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cmd_rdy_q    <= cmd_rdy_d;
    end
  end
endmodule
